// File: rtl/vend_pkg.sv
// Shared encodings and default widths for the vending purchase transaction controller.
package vend_pkg;

    localparam int unsigned VEND_ID_W   = 10;
    localparam int unsigned VEND_COST_W = 16;

    typedef enum logic [1:0] {
        TXN_OK       = 2'd0,
        TXN_SOLD_OUT = 2'd1,
        TXN_NO_FUNDS = 2'd2,
        TXN_ERROR    = 2'd3
    } txn_status_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StReq    = 3'd1,
        StWait   = 3'd2,
        StCheck  = 3'd3,
        StUpdate = 3'd4,
        StDone   = 3'd5
    } txn_state_e;

endpackage

// File: rtl/vend_txn_ctrl.sv
// Purchase transaction controller: fetch item cost/stock, decide outcome, request stock update.
// Optional VEND_STATS_EN adds stat_vends / stat_revenue counters.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned ID_W       = VEND_ID_W,
    parameter int unsigned COST_W     = VEND_COST_W,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic              pclk,
    input  logic              prstn,
    input  logic              cfg_mode,
    input  logic [ID_W-1:0]   num_items,
    input  logic              sel_valid,
    output logic              sel_ready,
    input  logic [ID_W-1:0]   sel_item_id,
    input  logic [COST_W-1:0] sel_credit,
    output logic              cfg_item_read_req,
    output logic              cfg_item_update_req,
    output logic [ID_W-1:0]   cfg_item_id,
    input  logic [15:0]       item_cost,
    input  logic [7:0]        item_available,
    input  logic              data_valid_apb,
    output logic              txn_done,
    output logic [1:0]        txn_status,
    output logic              dispense_valid,
    output logic [ID_W-1:0]   dispense_item_id,
    output logic [COST_W-1:0] change_amount
`ifdef VEND_STATS_EN
    ,
    output logic [31:0]       stat_vends,
    output logic [31:0]       stat_revenue
`endif
);

    localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);
    localparam int unsigned CmpW = (COST_W > 16) ? COST_W : 16;

    txn_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [ID_W-1:0]   id_q;
    logic [COST_W-1:0] credit_q;
    logic              bad_id_q;
    logic [15:0]       cost_q;
    logic [7:0]        avail_q;

    txn_status_e       status_q;
    logic [COST_W-1:0] change_q;
    logic [ID_W-1:0]   disp_id_q;

    logic              accept;
    logic              load_data;
    logic              enter_done;
    txn_status_e       fin_status;
    logic [COST_W-1:0] fin_change;
    logic [CmpW-1:0]   credit_ext, cost_ext;

    assign accept     = (state_q == StIdle) && sel_valid && !cfg_mode;
    assign cnt_inc    = cnt_q + CntW'(1);
    assign credit_ext = CmpW'(credit_q);
    assign cost_ext   = CmpW'(cost_q);

    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        load_data           = 1'b0;
        enter_done          = 1'b0;
        fin_status          = TXN_ERROR;
        fin_change          = credit_q;
        cfg_item_read_req   = 1'b0;
        cfg_item_update_req = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StReq;
                end
            end
            // An out-of-range id spends this cycle in REQ without a read so the error
            // completion lands two cycles after the accept edge.
            StReq: begin
                cnt_d = '0;
                if (cfg_mode || bad_id_q) begin
                    enter_done = 1'b1;
                end else begin
                    cfg_item_read_req = 1'b1;
                    state_d           = StWait;
                end
            end
            StWait: begin
                if (cfg_mode) begin
                    enter_done = 1'b1;
                end else if (data_valid_apb) begin
                    load_data = 1'b1;
                    state_d   = StCheck;
                end else if (cnt_inc == CntW'(RD_TIMEOUT)) begin
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StCheck: begin
                if (cfg_mode) begin
                    enter_done = 1'b1;
                end else if (avail_q == 8'd0) begin
                    enter_done = 1'b1;
                    fin_status = TXN_SOLD_OUT;
                end else if (credit_ext < cost_ext) begin
                    enter_done = 1'b1;
                    fin_status = TXN_NO_FUNDS;
                end else begin
                    state_d = StUpdate;
                end
            end
            // A late cfg_mode here must still suppress the update, so the sale becomes an error.
            StUpdate: begin
                enter_done = 1'b1;
                if (!cfg_mode) begin
                    cfg_item_update_req = 1'b1;
                    fin_status          = TXN_OK;
                    fin_change          = COST_W'(credit_ext - cost_ext);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (enter_done) begin
            state_d = StDone;
        end
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            id_q     <= '0;
            credit_q <= '0;
            bad_id_q <= 1'b0;
        end else if (accept) begin
            id_q     <= sel_item_id;
            credit_q <= sel_credit;
            bad_id_q <= (sel_item_id >= num_items);
        end
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            cost_q  <= '0;
            avail_q <= '0;
        end else if (load_data) begin
            cost_q  <= item_cost;
            avail_q <= item_available;
        end
    end

    // Result registers change only on DONE entry, so they hold until the next txn_done.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            status_q  <= TXN_OK;
            change_q  <= '0;
            disp_id_q <= '0;
        end else if (enter_done) begin
            status_q  <= fin_status;
            change_q  <= fin_change;
            disp_id_q <= id_q;
        end
    end

    assign sel_ready        = (state_q == StIdle) && !cfg_mode;
    assign cfg_item_id      = id_q;
    assign txn_done         = (state_q == StDone);
    assign txn_status       = status_q;
    assign dispense_valid   = txn_done && (status_q == TXN_OK);
    assign dispense_item_id = disp_id_q;
    assign change_amount    = change_q;

`ifdef VEND_STATS_EN
    logic [31:0] vends_q, revenue_q;

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            vends_q   <= '0;
            revenue_q <= '0;
        end else if (dispense_valid) begin
            vends_q   <= vends_q + 32'd1;
            revenue_q <= revenue_q + {16'd0, cost_q};
        end
    end

    assign stat_vends   = vends_q;
    assign stat_revenue = revenue_q;
`endif

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Self-checking bench for vend_txn_ctrl: directed vector table, corner sequences, random vs model.
module tb_vend_txn_ctrl;

    localparam int RD_TIMEOUT = 15;

    logic        pclk;
    logic        prstn;
    logic        cfg_mode;
    logic [9:0]  num_items;
    logic        sel_valid;
    logic        sel_ready;
    logic [9:0]  sel_item_id;
    logic [15:0] sel_credit;
    logic        cfg_item_read_req;
    logic        cfg_item_update_req;
    logic [9:0]  cfg_item_id;
    logic [15:0] item_cost;
    logic [7:0]  item_available;
    logic        data_valid_apb;
    logic        txn_done;
    logic [1:0]  txn_status;
    logic        dispense_valid;
    logic [9:0]  dispense_item_id;
    logic [15:0] change_amount;
`ifdef VEND_STATS_EN
    logic [31:0] stat_vends;
    logic [31:0] stat_revenue;
`endif

    vend_txn_ctrl #(
        .ID_W       (10),
        .COST_W     (16),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .pclk                (pclk),
        .prstn               (prstn),
        .cfg_mode            (cfg_mode),
        .num_items           (num_items),
        .sel_valid           (sel_valid),
        .sel_ready           (sel_ready),
        .sel_item_id         (sel_item_id),
        .sel_credit          (sel_credit),
        .cfg_item_read_req   (cfg_item_read_req),
        .cfg_item_update_req (cfg_item_update_req),
        .cfg_item_id         (cfg_item_id),
        .item_cost           (item_cost),
        .item_available      (item_available),
        .data_valid_apb      (data_valid_apb),
        .txn_done            (txn_done),
        .txn_status          (txn_status),
        .dispense_valid      (dispense_valid),
        .dispense_item_id    (dispense_item_id),
        .change_amount       (change_amount)
`ifdef VEND_STATS_EN
        ,
        .stat_vends          (stat_vends),
        .stat_revenue        (stat_revenue)
`endif
    );

    typedef struct {
        int id; int credit; int cost; int stock; int delay; int inj;
        int est; int ech; int eupd; int erd; int elat;
    } vec_t;

    vec_t tbl[12];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cost_mem[1024];
    int   stock_mem[1024];
    int   rsp_delay, rsp_cnt, rsp_id, inj_same;
    int   n_rd, n_upd, n_done, upd_id, upd_in_cfg;
    int   done_cyc, done_status, done_change, done_disp, done_disp_id, done_rdy;
    int   acc_cyc, rd0, up0, dn0, got_done;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial forever begin
        @(posedge pclk);
        cyc = cyc + 1;
    end

    // Config store: answers a read request rsp_delay cycles later (0 = never answers).
    initial forever begin
        @(posedge pclk);
        #1;
        data_valid_apb = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) begin
                data_valid_apb = 1'b1;
                item_cost      = 16'(cost_mem[rsp_id]);
                item_available = 8'(stock_mem[rsp_id]);
            end
        end
        if (cfg_item_read_req === 1'b1) begin
            rsp_id  = int'(cfg_item_id);
            rsp_cnt = rsp_delay;
            if (inj_same != 0) begin
                data_valid_apb = 1'b1;
                item_cost      = 16'd0;
                item_available = 8'd9;
            end
        end
    end

    initial forever begin
        @(negedge pclk);
        if (cfg_item_read_req === 1'b1) n_rd = n_rd + 1;
        if (cfg_item_update_req === 1'b1) begin
            n_upd  = n_upd + 1;
            upd_id = int'(cfg_item_id);
            if (cfg_mode) upd_in_cfg = upd_in_cfg + 1;
            if (stock_mem[cfg_item_id] > 0) stock_mem[cfg_item_id] = stock_mem[cfg_item_id] - 1;
        end
        if (txn_done === 1'b1) begin
            n_done       = n_done + 1;
            done_cyc     = cyc;
            done_status  = int'(txn_status);
            done_change  = int'(change_amount);
            done_disp    = int'(dispense_valid);
            done_disp_id = int'(dispense_item_id);
            done_rdy     = int'(sel_ready);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic accept_txn(input int id, input int credit, input int delay, input int inj);
        rsp_delay = delay;
        inj_same  = inj;
        @(posedge pclk);
        #1;
        sel_valid   = 1'b1;
        sel_item_id = id[9:0];
        sel_credit  = credit[15:0];
        rd0 = n_rd;
        up0 = n_upd;
        dn0 = n_done;
        @(posedge pclk);
        #1;
        acc_cyc   = cyc;
        sel_valid = 1'b0;
    endtask

    task automatic finish_txn();
        got_done = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk);
            #1;
            if (n_done != dn0) begin
                got_done = 1;
                break;
            end
        end
    endtask

    task automatic expect_txn(input string tag, input int id, input int est, input int ech,
                              input int eupd, input int erd, input int elat);
        chk({tag, "_done_seen"}, got_done, 1);
        chk({tag, "_status"}, done_status, est);
        chk({tag, "_change"}, done_change, ech);
        chk({tag, "_dispense_valid"}, done_disp, (est == 0) ? 1 : 0);
        chk({tag, "_dispense_id"}, done_disp_id, id % 1024);
        chk({tag, "_read_reqs"}, n_rd - rd0, erd);
        chk({tag, "_update_reqs"}, n_upd - up0, eupd);
        chk({tag, "_latency"}, done_cyc - acc_cyc + 1, elat);
        chk({tag, "_ready_at_done"}, done_rdy, 0);
        if (eupd != 0) chk({tag, "_update_id"}, upd_id, id);
    endtask

    // Outcome from the purchase rules; data arriving on wait cycle d (1..RD_TIMEOUT) is used.
    task automatic model(input int id, input int credit, input int delay,
                         output int st, output int ch, output int upd, output int rd,
                         output int lat);
        ch  = credit;
        upd = 0;
        rd  = 1;
        if (id >= int'(num_items)) begin
            st = 3; rd = 0; lat = 2;
        end else if (delay == 0 || delay > RD_TIMEOUT) begin
            st = 3; lat = 2 + RD_TIMEOUT;
        end else if (stock_mem[id] == 0) begin
            st = 1; lat = delay + 3;
        end else if (credit < cost_mem[id]) begin
            st = 2; lat = delay + 3;
        end else begin
            st = 0; ch = credit - cost_mem[id]; upd = 1; lat = delay + 4;
        end
    endtask

    initial begin
        int st, ch, upd, rd, lat, id, credit, delay, inj, ones;

        prstn = 1'b0; cfg_mode = 1'b0; num_items = 10'd10;
        sel_valid = 1'b0; sel_item_id = '0; sel_credit = '0;
        data_valid_apb = 1'b0; item_cost = '0; item_available = '0;
        rsp_delay = 0; rsp_cnt = 0; rsp_id = 0; inj_same = 0;
        n_rd = 0; n_upd = 0; n_done = 0; upd_id = 0; upd_in_cfg = 0;
        done_cyc = 0; done_status = 0; done_change = 0; done_disp = 0;
        done_disp_id = 0; done_rdy = 0;
        for (int i = 0; i < 1024; i++) begin
            cost_mem[i]  = 0;
            stock_mem[i] = 0;
        end

        //          id  credit  cost stock dly inj  st  change upd rd lat
        tbl[0]  = '{5,    200,   150,  3,   1,  0,  0,    50,  1, 1,  5};
        tbl[1]  = '{7,    500,   100,  0,   1,  0,  1,   500,  0, 1,  4};
        tbl[2]  = '{2,    299,   300,  4,   1,  0,  2,   299,  0, 1,  4};
        tbl[3]  = '{10,   123,    10,  5,   1,  0,  3,   123,  0, 0,  2};
        tbl[4]  = '{1,     80,    50,  2,   0,  0,  3,    80,  0, 1, 17};
        tbl[5]  = '{4,     40,     0,  1,   2,  0,  0,    40,  1, 1,  6};
        tbl[6]  = '{3,    300,   300,  1,   1,  1,  0,     0,  1, 1,  5};
        tbl[7]  = '{8,    500,    10,  5,  15,  0,  0,   490,  1, 1, 19};
        tbl[8]  = '{9,    500,    10,  5,  16,  0,  3,   500,  0, 1, 17};
        tbl[9]  = '{0,  65535, 65535,255,   1,  0,  0,     0,  1, 1,  5};
        tbl[10] = '{9,      0,     1,  1,   1,  0,  2,     0,  0, 1,  4};
        tbl[11] = '{1023,   7,     5,  5,   1,  0,  3,     7,  0, 0,  2};

        repeat (3) @(posedge pclk);
        #1 prstn = 1'b1;
        @(negedge pclk);
        chk("rst_sel_ready", int'(sel_ready), 1);
        chk("rst_read_req", int'(cfg_item_read_req), 0);
        chk("rst_update_req", int'(cfg_item_update_req), 0);
        chk("rst_txn_done", int'(txn_done), 0);
        chk("rst_status", int'(txn_status), 0);
        chk("rst_dispense_valid", int'(dispense_valid), 0);
        chk("rst_dispense_id", int'(dispense_item_id), 0);
        chk("rst_change", int'(change_amount), 0);
        chk("rst_cfg_item_id", int'(cfg_item_id), 0);

        for (int i = 0; i < 12; i++) begin
            cost_mem[tbl[i].id]  = tbl[i].cost;
            stock_mem[tbl[i].id] = tbl[i].stock;
            accept_txn(tbl[i].id, tbl[i].credit, tbl[i].delay, tbl[i].inj);
            finish_txn();
            expect_txn($sformatf("vec%0d", i), tbl[i].id, tbl[i].est, tbl[i].ech,
                       tbl[i].eupd, tbl[i].erd, tbl[i].elat);
        end

        // Selections presented while busy must be dropped.
        cost_mem[6] = 20; stock_mem[6] = 2;
        accept_txn(6, 100, 3, 0);
        @(posedge pclk); #1;
        sel_valid = 1'b1; sel_item_id = 10'd8; sel_credit = 16'd7;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        sel_valid = 1'b0;
        finish_txn();
        expect_txn("busy", 6, 0, 80, 1, 1, 7);
        repeat (4) @(negedge pclk);
        chk("busy_no_extra_done", n_done - dn0, 1);
        chk("busy_no_extra_read", n_rd - rd0, 1);

        // cfg_mode raised while waiting for data aborts with ERROR and blocks new selections.
        cost_mem[3] = 10; stock_mem[3] = 5;
        accept_txn(3, 55, 0, 0);
        @(posedge pclk); #1;
        cfg_mode = 1'b1;
        finish_txn();
        expect_txn("cfg_abort", 3, 3, 55, 0, 1, 3);
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (sel_ready) ones = ones + 1;
        end
        chk("cfg_ready_blocked", ones, 0);
        @(posedge pclk); #1;
        cfg_mode = 1'b0;
        @(negedge pclk);
        chk("cfg_ready_restored", int'(sel_ready), 1);

        // Asynchronous reset mid-wait abandons the transaction silently.
        cost_mem[4] = 10; stock_mem[4] = 2;
        accept_txn(4, 30, 0, 0);
        repeat (3) @(posedge pclk);
        #1 prstn = 1'b0;
        rsp_cnt = 0;
        @(negedge pclk);
        chk("mrst_status", int'(txn_status), 0);
        chk("mrst_change", int'(change_amount), 0);
        chk("mrst_dispense_id", int'(dispense_item_id), 0);
        chk("mrst_cfg_item_id", int'(cfg_item_id), 0);
        chk("mrst_txn_done", int'(txn_done), 0);
        @(posedge pclk); #1 prstn = 1'b1;
        repeat (4) @(negedge pclk);
        chk("mrst_no_done", n_done - dn0, 0);
        chk("mrst_no_update", n_upd - up0, 0);
        chk("mrst_ready", int'(sel_ready), 1);

`ifdef VEND_STATS_EN
        cost_mem[5] = 150; stock_mem[5] = 3;
        cost_mem[6] = 80;  stock_mem[6] = 3;
        accept_txn(5, 200, 1, 0);
        finish_txn();
        expect_txn("stats_a", 5, 0, 50, 1, 1, 5);
        accept_txn(6, 100, 1, 0);
        finish_txn();
        expect_txn("stats_b", 6, 0, 20, 1, 1, 5);
        @(negedge pclk);
        chk("stat_vends", int'(stat_vends), 2);
        chk("stat_revenue", int'(stat_revenue), 230);
`endif

        num_items = 10'd200;
        for (int i = 0; i < 224; i++) begin
            cost_mem[i]  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 500));
            stock_mem[i] = int'($urandom_range(0, 3));
        end
        for (int n = 0; n < 150; n++) begin
            id     = int'($urandom_range(0, 223));
            credit = int'($urandom_range(0, 600));
            delay  = int'($urandom_range(0, 17));
            inj    = ($urandom_range(0, 7) == 0) ? 1 : 0;
            model(id, credit, delay, st, ch, upd, rd, lat);
            accept_txn(id, credit, delay, inj);
            finish_txn();
            expect_txn($sformatf("rnd%0d", n), id, st, ch, upd, rd, lat);
        end

        chk("update_while_cfg_mode", upd_in_cfg, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
